// File: rtl/layer1_weight_loader.sv
// layer1_weight_loader: packs RELU_NODES serial weights per row and strobes each row into Layer1WeightStorage
// Ports: clk, reset (async, active-high), start (begin load at row 0),
//   in_valid/in_data/in_ready (weight stream handshake), writeEnable/NodeSelect/writeIn
//   (one strobe per packed row, lane k at [k*W +: W]), busy (FILL or WRITE), done (held until next start).
module layer1_weight_loader #(
  parameter int RELU_NODES = 32,
  parameter int W = 8,
  parameter int NUM_INPUTS = 784,
  parameter int SEL_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  output logic                    writeEnable,
  output logic [SEL_WIDTH-1:0]    NodeSelect,
  output logic [RELU_NODES*W-1:0] writeIn,
  output logic                    busy,
  output logic                    done
);
  localparam int LW = RELU_NODES > 1 ? $clog2(RELU_NODES) : 1;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} stateType;
  stateType state, nextState;
  logic [LW-1:0] laneCnt;
  logic [SEL_WIDTH-1:0] rowCnt;
  logic [RELU_NODES*W-1:0] rowBuf, fullRow;
  logic take, lastLane, lastRow, launch;
  always_comb begin
    take = in_valid & in_ready;
    lastLane = laneCnt == LW'(RELU_NODES - 1);
    lastRow = rowCnt == SEL_WIDTH'(NUM_INPUTS - 1);
    launch = start & (state == IDLE || state == DONE);
    // row as it will look once the weight on in_data is accepted
    fullRow = rowBuf;
    fullRow[laneCnt*W +: W] = in_data;
    nextState = state;
    nextState = launch ? FILL
              : state == FILL ? (take && lastLane ? WRITE : FILL)
              : state == WRITE ? (lastRow ? DONE : FILL)
              : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_ready <= 1'b0;
      writeEnable <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      laneCnt <= '0;
      rowCnt <= '0;
      rowBuf <= '0;
      writeIn <= '0;
      NodeSelect <= '0;
    end else begin
      in_ready <= nextState == FILL;
      writeEnable <= nextState == WRITE;
      busy <= nextState == FILL || nextState == WRITE;
      done <= nextState == DONE;
      if (launch) begin
        laneCnt <= '0;
        rowCnt <= '0;
      end else if (take) begin
        rowBuf <= fullRow;
        laneCnt <= lastLane ? '0 : laneCnt + 1'b1;
        if (lastLane) begin
          writeIn <= fullRow;
          NodeSelect <= rowCnt;
        end
      end else if (state == WRITE && !lastRow) rowCnt <= rowCnt + 1'b1;
    end
endmodule
